// File: rtl/vga_sync_gen.sv
// Parametrised VESA raster timing generator: sync, display enable, visible-aligned
// coordinates, a lead-timed prefetch coordinate stream and line/frame start strobes.
module vga_sync_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FRONT   = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BACK    = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 38,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1,
  parameter int PREFETCH  = 16,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          inDisplayArea,
  output logic [CW-1:0] counterX,
  output logic [CW-1:0] counterY,
  output logic          inPrefetchArea,
  output logic [CW-1:0] prefetchCounterX,
  output logic [CW-1:0] prefetchCounterY,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int AW        = CW + 1;
  localparam int H_SYNC_LO = H_VISIBLE + H_FRONT;
  localparam int V_SYNC_LO = V_VISIBLE + V_FRONT;
  localparam logic H_ACT   = (H_POL != 0);
  localparam logic V_ACT   = (V_POL != 0);

  // One extra bit so that sums such as h_cnt + PREFETCH never truncate.
  function automatic logic [AW-1:0] widen(input logic [CW-1:0] val);
    return {1'b0, val};
  endfunction

  function automatic logic inZone(input logic [AW-1:0] val, input int lo, input int len);
    return (val >= AW'(lo)) && (val < AW'(lo + len));
  endfunction

  function automatic logic syncLevel(input logic active, input logic actLevel);
    return active ? actLevel : ~actLevel;
  endfunction

  // Stage 0: raster counters, zero at the first visible pixel of the frame
  logic [CW-1:0] hCnt_p0;
  logic [CW-1:0] vCnt_p0;
  logic          hLast_p0;
  logic          vLast_p0;

  assign hLast_p0 = (widen(hCnt_p0) == AW'(H_TOTAL - 1));
  assign vLast_p0 = (widen(vCnt_p0) == AW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCnt_p0 <= '0;
      vCnt_p0 <= '0;
    end else begin
      if (hLast_p0) begin
        hCnt_p0 <= '0;
        vCnt_p0 <= vLast_p0 ? '0 : vCnt_p0 + 1'b1;
      end else begin
        hCnt_p0 <= hCnt_p0 + 1'b1;
      end
    end
  end

  // Stage 0 decode: zones, strobes and the prefetch lead
  logic [AW-1:0] pSum_p0;
  logic          pWrap_p0;
  logic [CW-1:0] pX_p0;
  logic [CW-1:0] pY_p0;
  logic          hSync_p0;
  logic          vSync_p0;
  logic          de_p0;
  logic          pre_p0;
  logic          lineStart_p0;
  logic          frameStart_p0;

  always_comb begin
    pSum_p0  = widen(hCnt_p0) + AW'(PREFETCH);
    pWrap_p0 = (pSum_p0 >= AW'(H_TOTAL));
    // The true column is below 2^CW, so the modular CW-bit subtraction is exact.
    pX_p0    = pWrap_p0 ? (hCnt_p0 + CW'(PREFETCH) - CW'(H_TOTAL))
                        : (hCnt_p0 + CW'(PREFETCH));
    if (!pWrap_p0) begin
      pY_p0 = vCnt_p0;
    end else if (vLast_p0) begin
      pY_p0 = '0;
    end else begin
      pY_p0 = vCnt_p0 + 1'b1;
    end

    hSync_p0      = syncLevel(inZone(widen(hCnt_p0), H_SYNC_LO, H_SYNC), H_ACT);
    vSync_p0      = syncLevel(inZone(widen(vCnt_p0), V_SYNC_LO, V_SYNC), V_ACT);
    de_p0         = (widen(hCnt_p0) < AW'(H_VISIBLE)) && (widen(vCnt_p0) < AW'(V_VISIBLE));
    pre_p0        = (widen(pX_p0) < AW'(H_VISIBLE)) && (widen(pY_p0) < AW'(V_VISIBLE));
    lineStart_p0  = (hCnt_p0 == '0) && (widen(vCnt_p0) < AW'(V_VISIBLE));
    frameStart_p0 = (hCnt_p0 == '0) && (vCnt_p0 == '0);
  end

  // Stage 1: every output registered once so sync, enable and coordinates stay aligned
  logic          hSync_p1;
  logic          vSync_p1;
  logic          de_p1;
  logic [CW-1:0] cX_p1;
  logic [CW-1:0] cY_p1;
  logic          pre_p1;
  logic [CW-1:0] pX_p1;
  logic [CW-1:0] pY_p1;
  logic          lineStart_p1;
  logic          frameStart_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hSync_p1      <= ~H_ACT;
      vSync_p1      <= ~V_ACT;
      de_p1         <= 1'b0;
      cX_p1         <= '0;
      cY_p1         <= '0;
      pre_p1        <= 1'b0;
      pX_p1         <= '0;
      pY_p1         <= '0;
      lineStart_p1  <= 1'b0;
      frameStart_p1 <= 1'b0;
    end else begin
      hSync_p1      <= hSync_p0;
      vSync_p1      <= vSync_p0;
      de_p1         <= de_p0;
      cX_p1         <= hCnt_p0;
      cY_p1         <= vCnt_p0;
      pre_p1        <= pre_p0;
      pX_p1         <= pX_p0;
      pY_p1         <= pY_p0;
      lineStart_p1  <= lineStart_p0;
      frameStart_p1 <= frameStart_p0;
    end
  end

  assign vga_h_sync       = hSync_p1;
  assign vga_v_sync       = vSync_p1;
  assign inDisplayArea    = de_p1;
  assign counterX         = cX_p1;
  assign counterY         = cY_p1;
  assign inPrefetchArea   = pre_p1;
  assign prefetchCounterX = pX_p1;
  assign prefetchCounterY = pY_p1;
  assign line_start       = lineStart_p1;
  assign frame_start      = frameStart_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every cycle against a raster
// model derived from the elapsed clock count since reset release.
module tb_vga_sync_gen;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int hp; int vp; int pf;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] cx;
    logic [10:0] cy;
    logic        pa;
    logic [10:0] px;
    logic [10:0] py;
    logic        ls;
    logic        fs;
  } out_t;

  localparam cfg_t CA = '{hv:8, hf:2, hs:2, hb:2, vv:4, vf:1, vs:1, vb:1, hp:1, vp:1, pf:3};
  localparam cfg_t CB = '{hv:8, hf:2, hs:2, hb:2, vv:4, vf:1, vs:1, vb:1, hp:0, vp:0, pf:0};
  localparam cfg_t CC = '{hv:1280, hf:48, hs:112, hb:248, vv:1024, vf:1, vs:3, vb:38,
                          hp:1, vp:1, pf:16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  logic aHs, aVs, aDe, aPa, aLs, aFs;
  logic [10:0] aCx, aCy, aPx, aPy;
  logic bHs, bVs, bDe, bPa, bLs, bFs;
  logic [10:0] bCx, bCy, bPx, bPy;
  logic cHs, cVs, cDe, cPa, cLs, cFs;
  logic [10:0] cCx, cCy, cPx, cPy;
  out_t gA, gB, gC;

  assign gA = {aHs, aVs, aDe, aCx, aCy, aPa, aPx, aPy, aLs, aFs};
  assign gB = {bHs, bVs, bDe, bCx, bCy, bPa, bPx, bPy, bLs, bFs};
  assign gC = {cHs, cVs, cDe, cCx, cCy, cPa, cPx, cPy, cLs, cFs};

  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_VISIBLE(4),
                 .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .H_POL(1), .V_POL(1),
                 .PREFETCH(3), .CW(11)) dutA (
    .clk(clk), .rst_n(rst_n), .vga_h_sync(aHs), .vga_v_sync(aVs), .inDisplayArea(aDe),
    .counterX(aCx), .counterY(aCy), .inPrefetchArea(aPa), .prefetchCounterX(aPx),
    .prefetchCounterY(aPy), .line_start(aLs), .frame_start(aFs));

  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_VISIBLE(4),
                 .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .H_POL(0), .V_POL(0),
                 .PREFETCH(0), .CW(11)) dutB (
    .clk(clk), .rst_n(rst_n), .vga_h_sync(bHs), .vga_v_sync(bVs), .inDisplayArea(bDe),
    .counterX(bCx), .counterY(bCy), .inPrefetchArea(bPa), .prefetchCounterX(bPx),
    .prefetchCounterY(bPy), .line_start(bLs), .frame_start(bFs));

  vga_sync_gen dutC (
    .clk(clk), .rst_n(rst_n), .vga_h_sync(cHs), .vga_v_sync(cVs), .inDisplayArea(cDe),
    .counterX(cCx), .counterY(cCy), .inPrefetchArea(cPa), .prefetchCounterX(cPx),
    .prefetchCounterY(cPy), .line_start(cLs), .frame_start(cFs));

  // Outputs expected t clocks after the first registered pixel.
  function automatic out_t model(input cfg_t c, input int t);
    out_t o;
    int ht, vt, h, v, p, px, py;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    h  = t % ht;
    v  = (t / ht) % vt;
    p  = h + c.pf;
    if (p >= ht) begin
      px = p - ht;
      py = (v + 1) % vt;
    end else begin
      px = p;
      py = v;
    end
    o.hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.hp[0] : ~c.hp[0];
    o.vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.vp[0] : ~c.vp[0];
    o.de = (h < c.hv) && (v < c.vv);
    o.cx = 11'(h);
    o.cy = 11'(v);
    o.pa = (px < c.hv) && (py < c.vv);
    o.px = 11'(px);
    o.py = 11'(py);
    o.ls = (h == 0) && (v < c.vv);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic out_t rstOut(input cfg_t c);
    out_t o;
    o    = '0;
    o.hs = ~c.hp[0];
    o.vs = ~c.vp[0];
    return o;
  endfunction

  function automatic out_t expectOut(input cfg_t c);
    if (!rst_n || n == 0) return rstOut(c);
    return model(c, n - 1);
  endfunction

  task automatic chk(input string name, input out_t got, input out_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t n=%0d got=%h want=%h", name, $time, n, got, want);
    end
  endtask

  task automatic chkInt(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    chk("cfgA", gA, expectOut(CA));
    chk("cfgB", gB, expectOut(CB));
    chk("cfgC", gC, expectOut(CC));
  end

  task automatic releaseReset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic asyncReset(input int offset, input int holdCycles);
    @(posedge clk);
    #(offset) rst_n = 1'b0;
    #1;
    chk("asyncA", gA, rstOut(CA));
    chk("asyncB", gB, rstOut(CB));
    chk("asyncC", gC, rstOut(CC));
    repeat (holdCycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    out_t m;
    int deCnt, fsCnt, hsCnt, vsCnt, waited;

    // Hand-computed points that pin the model.
    m = model(CA, 25);  chkInt("pinPx1", m.px, 0); chkInt("pinPy1", m.py, 2); chkInt("pinPa1", m.pa, 1);
    m = model(CA, 53);  chkInt("pinPy3", m.py, 4); chkInt("pinPa3", m.pa, 0);
    m = model(CA, 95);  chkInt("pinPy6", m.py, 0);
    m = model(CA, 10);  chkInt("pinHs10", m.hs, 1);
    m = model(CA, 9);   chkInt("pinHs9", m.hs, 0);
    m = model(CA, 70);  chkInt("pinVs70", m.vs, 1);
    m = model(CA, 84);  chkInt("pinVs84", m.vs, 0);
    m = model(CC, 1328); chkInt("pinCHs", m.hs, 1);
    m = model(CC, 1327); chkInt("pinCHs0", m.hs, 0);
    m = model(CC, 1672 + 1688 * 1065);
    chkInt("pinCPa", m.pa, 1); chkInt("pinCPx", m.px, 0); chkInt("pinCPy", m.py, 0);
    m = model(CC, 1671 + 1688 * 1065); chkInt("pinCPa0", m.pa, 0);
    m = model(CC, 1688 * 1066); chkInt("pinCFs", m.fs, 1);
    m = rstOut(CB); chkInt("pinBIdle", m.hs, 1);

    repeat (3) @(negedge clk);
    releaseReset();

    // One full small frame: t = 0..97.
    deCnt = 0; fsCnt = 0; hsCnt = 0; vsCnt = 0;
    repeat (98) begin
      @(negedge clk);
      deCnt += int'(aDe);
      fsCnt += int'(aFs);
      hsCnt += int'(aHs);
      vsCnt += int'(aVs);
    end
    chkInt("frameDe", deCnt, 32);
    chkInt("frameFs", fsCnt, 1);
    chkInt("frameHs", hsCnt, 14);
    chkInt("frameVs", vsCnt, 14);
    @(negedge clk);
    chkInt("fsPeriod", int'(aFs), 1);

    // Mid-frame abort at column 5, row 2.
    waited = 0;
    while (!(aCx == 11'd5 && aCy == 11'd2) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chkInt("seekTimeout", int'(waited < 300), 1);
    asyncReset(1, 3);
    @(negedge clk);
    chkInt("restartFs", int'(aFs), 1);
    chkInt("restartCx", int'(aCx), 0);

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(20, 300)) @(negedge clk);
      asyncReset(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    end

    repeat (4000) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VESA raster timing generator producing horizontal/vertical sync, display enable, visible-area pixel coordinates and a lead-timed prefetch coordinate stream for the pixel pipeline. Replaces the fixed 1280x1024 generator: every porch and sync width, both sync polarities and the prefetch lead are parameters. All logic runs in the pixel clock domain (no clocking on the sync output). Adds asynchronous reset plus line- and frame-start strobes for the cellular-automaton frame buffer controller.

## Interface
- H_VISIBLE, 1280, active pixels per line
- H_FRONT, 48, horizontal front porch (clk)
- H_SYNC, 112, horizontal sync width (clk)
- H_BACK, 248, horizontal back porch (clk)
- V_VISIBLE, 1024, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BACK, 38, vertical back porch (lines)
- H_POL, 1, h_sync active level (1 = positive)
- V_POL, 1, v_sync active level
- PREFETCH, 16, prefetch lead in clk; legal range 0..H_FRONT+H_SYNC+H_BACK
- CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- vga_h_sync  out  1  horizontal sync, polarity H_POL
- vga_v_sync  out  1  vertical sync, polarity V_POL
- inDisplayArea  out  1  pixel at counterX/counterY is visible
- counterX  out  CW  visible-aligned column
- counterY  out  CW  visible-aligned row
- inPrefetchArea  out  1  prefetchCounterX/prefetchCounterY address a visible pixel
- prefetchCounterX  out  CW  column needed PREFETCH clk ahead
- prefetchCounterY  out  CW  row of that column
- line_start  out  1  one-clk pulse with first visible pixel of each visible line
- frame_start  out  1  one-clk pulse with pixel (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Defaults: 1688 x 1066.
- Internal h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1, both zero at first visible pixel of frame. h_cnt wraps H_TOTAL-1 -> 0; v_cnt advances only on that wrap, wrapping V_TOTAL-1 -> 0 (simultaneous wrap returns to 0,0).
- Horizontal zones: visible [0,H_VISIBLE), front, sync [H_VISIBLE+H_FRONT, +H_SYNC), back. Vertical likewise in lines; v_sync changes only when h_cnt wraps (aligned to line start, not to h_sync edge).
- h_sync active iff h_cnt in sync zone; v_sync active iff v_cnt in vertical sync zone. Inactive level = ~POL.
- inDisplayArea = h_cnt < H_VISIBLE && v_cnt < V_VISIBLE; counterX/counterY = h_cnt/v_cnt.
- Prefetch: p = h_cnt+PREFETCH; if p >= H_TOTAL then px = p-H_TOTAL, py = v_cnt+1 (V_TOTAL-1 -> 0); else px = p, py = v_cnt. inPrefetchArea = px < H_VISIBLE && py < V_VISIBLE. prefetchCounterX/Y = px/py. PREFETCH = 0 makes prefetch outputs equal display outputs.
- line_start = h_cnt==0 && v_cnt<V_VISIBLE; frame_start = h_cnt==0 && v_cnt==0.
- Arithmetic in CW+1 bits; no truncation inside legal parameter range.

## Timing
- All outputs registered: output at edge n+1 reflects counters at edge n (latency 1, identical for every output, so sync/DE/coords stay mutually aligned).
- rst_n low: counters 0 immediately; vga_h_sync=~H_POL, vga_v_sync=~V_POL, inDisplayArea=0, inPrefetchArea=0, all coordinates 0, strobes 0.
- First rising edge after rst_n release registers (0,0): inDisplayArea=1, frame_start=1, line_start=1; counters then 1.
- Reset mid-frame aborts the frame; restart is identical to power-up.

## Test plan
- Small config H 8/2/2/2, V 4/1/1/1, PREFETCH 3: release reset -> frame_start every 98 clk, inDisplayArea high 8 of each 14 clk for 4 lines, 32 DE cycles/frame.
- Same config: h_sync active exactly clk where counterX in 10..11; v_sync active for the 14 clk of line 5 only, switching with counterX 13->0.
- Prefetch wrap: at counterX=11,row 1 -> prefetchCounterX=0, prefetchCounterY=2, inPrefetchArea=1; at counterX=11,row 3 -> row 4, inPrefetchArea=0; at row 6 -> prefetchCounterY=0.
- Polarity H_POL=0,V_POL=0: syncs idle high in reset and pulse low in same cycles as positive case.
- Assert rst_n low at counterX=5,row 2 for 3 clk -> outputs reset values asynchronously; restart matches power-up sequence.
- Default 1280x1024: 1688 clk/line, 1066 lines, h_sync 112 clk starting counterX=1328, inPrefetchArea rises at counterX=1672 of line 1065.
